// File: rtl/cpu_pkg.sv
// Shared types and sizing for the instruction fetch stage.
package cpu_pkg;

    // Address width the fetch buffer entry type is built for; instruction width is twice this.
    localparam int FETCH_WIDTH = 8;
    localparam int FETCH_DEPTH = 2;
    localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [2*FETCH_WIDTH-1:0] instr;
        logic [FETCH_WIDTH-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched words and their PCs; entry 0 is always the head so the
// head output comes straight from a register.
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     entry0_q, entry0_d;
    fetch_entry_t     entry1_q, entry1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Next-state of the FIFO: flush wins, otherwise push/pop with shift toward the head.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            // Head data is left in place so the output does not glitch; count alone marks it empty.
            count_d = '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count_q == '0) begin
                        entry0_d = push_entry;
                    end else begin
                        entry1_d = push_entry;
                    end
                    count_d = count_q + CNT_W'(1);
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - CNT_W'(1);
                end
                2'b11: begin
                    if (count_q == CNT_W'(1)) begin
                        entry0_d = push_entry;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FIFO storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = entry0_q;

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q != CNT_W'(FETCH_DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: run/idle control, PC sequencing, one-deep in-flight read tracking
// and the issue throttle that keeps the 2-entry buffer from ever overflowing.
// WIDTH must equal cpu_pkg::FETCH_WIDTH because the buffer entry type is sized from it.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_pc,
    output logic               mem_read,
    output logic [WIDTH-1:0]   mem_addr,
    input  logic [2*WIDTH-1:0] mem_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [2*WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0]   instr_pc,
    output logic               running
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     push_entry;
    logic             push;
    logic             pop;
    logic             issue;
    logic [CNT_W:0]   occupancy;

    assign instr_valid = (buf_count != '0);

    // Issue throttle: a new read is only allowed if the word will have a free slot when it lands.
    always_comb begin
        pop       = instr_valid && instr_ready;
        occupancy = {1'b0, buf_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        issue     = (state_q == RUN) && !redirect_valid && (occupancy < (CNT_W + 1)'(FETCH_DEPTH));
    end

    // Run/idle FSM: stop has priority over start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop)           state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // PC and in-flight tracking: redirect replaces the PC and suppresses issue in the same cycle.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + WIDTH'(1);
            inflight_pc_d = pc_q;
        end
    end

    // Control and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A word returning in a redirect cycle belongs to the old path and is dropped.
    assign push             = inflight_q && !redirect_valid;
    assign push_entry.instr = mem_data;
    assign push_entry.pc    = inflight_pc_q;

    fetch_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (buf_count),
        .head       (buf_head)
    );

    assign mem_read  = issue;
    assign mem_addr  = pc_q;
    assign running   = (state_q == RUN);
    assign instr_out = buf_head.instr;
    assign instr_pc  = buf_head.pc;

    a_addr_known : assert property (@(posedge clk) disable iff (rst)
        mem_read |-> !$isunknown(mem_addr));

    a_stall_stable : assert property (@(posedge clk) disable iff (rst)
        (instr_valid && !instr_ready) |=> ($stable(instr_out) && $stable(instr_pc)));

endmodule
